// File: rtl/uart_tx_if.sv
// Transmit-side handshake for uart_tx: byte strobe and data in, status and
// serial line out. The master modport is the byte producer, slave is the UART.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_end;
  logic       tx;

  modport master (
    output tx_start, tx_data,
    input  tx_ready, tx_busy, tx_end, tx
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_ready, tx_busy, tx_end, tx
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small power-of-two byte FIFO in front of it.
// Back-to-back frames are sent without an idle gap while the FIFO holds data.
module uart_tx #(
  parameter int DIV_RATE   = 260,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int DW = $clog2(DIV_RATE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATE - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [AW:0]     count_q, count_d;
  logic [DW-1:0]   divCnt_q;
  logic [2:0]      bitCnt_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            txEnd_q;
  logic            push;
  logic            pop;
  logic            divDone;

  assign bus.tx_ready = (count_q < DEPTH_C);
  assign bus.tx_busy  = (state_q != IDLE) || (count_q != '0);
  assign bus.tx_end   = txEnd_q;
  assign bus.tx       = tx_q;

  // A pop happens whenever the transmitter is free to start a new frame:
  // from IDLE, or at the very last clock of a stop bit.
  always_comb begin
    divDone = (divCnt_q == '0);
    push    = bus.tx_start && bus.tx_ready;
    pop     = (count_q != '0) &&
              ((state_q == IDLE) || ((state_q == STOP) && divDone));
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= bus.tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Frame sequencer; tx and tx_end are registered here so the line is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      divCnt_q <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      txEnd_q  <= 1'b0;
    end else begin
      txEnd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q  <= mem_q[rdPtr_q];
            tx_q     <= 1'b0;
            divCnt_q <= DIV_LAST;
            state_q  <= START;
          end
        end
        START: begin
          if (!divDone) begin
            divCnt_q <= divCnt_q - DW'(1);
          end else begin
            divCnt_q <= DIV_LAST;
            tx_q     <= shift_q[0];
            shift_q  <= {1'b0, shift_q[7:1]};
            bitCnt_q <= 3'd0;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (!divDone) begin
            divCnt_q <= divCnt_q - DW'(1);
          end else begin
            divCnt_q <= DIV_LAST;
            if (bitCnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q     <= shift_q[0];
              shift_q  <= {1'b0, shift_q[7:1]};
              bitCnt_q <= bitCnt_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (!divDone) begin
            divCnt_q <= divCnt_q - DW'(1);
          end else begin
            txEnd_q <= 1'b1;
            if (pop) begin
              shift_q  <= mem_q[rdPtr_q];
              tx_q     <= 1'b0;
              divCnt_q <= DIV_LAST;
              state_q  <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Structural invariants of the FIFO and the end-of-frame pulse.
  assert property (@(posedge clk) disable iff (reset) count_q <= DEPTH_C);
  assert property (@(posedge clk) disable iff (reset) txEnd_q |=> !txEnd_q);
  assert property (@(posedge clk) disable iff (reset) (state_q == IDLE) |-> tx_q);

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx: a frame-level model predicts accepted
// bytes and frame start edges; a line receiver decodes tx and checks them.
module tb_uart_tx;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  uart_tx_if ifc();

  uart_tx #(.DIV_RATE(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int edgeCnt = 0;
  always @(posedge clk) edgeCnt = edgeCnt + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] modelQ[$];
  logic [7:0] sbData[$];
  int         sbStart[$];
  bit         inFrame = 1'b0;
  int         frameEnd = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edgeCnt);
    end
  endtask

  task automatic startFrame(input int e);
    void'(modelQ.pop_front());
    sbStart.push_back(e);
    frameEnd = e + 10 * D;
    inFrame  = 1'b1;
  endtask

  // Called at a falling edge; drives one clock of stimulus and advances the model.
  task automatic applyStimulus(input bit start, input logic [7:0] data);
    bit rdy;
    bit endExp;
    int e;
    ifc.tx_start = start;
    ifc.tx_data  = data;
    rdy = (modelQ.size() < DEPTH);
    checkOutput("tx_ready", ifc.tx_ready, rdy);
    checkOutput("tx_busy", ifc.tx_busy, inFrame || (modelQ.size() != 0));
    e = edgeCnt + 1;
    endExp = 1'b0;
    if (!inFrame) begin
      if (modelQ.size() != 0) startFrame(e);
    end else if (e == frameEnd) begin
      endExp = 1'b1;
      if (modelQ.size() != 0) startFrame(e);
      else inFrame = 1'b0;
    end
    if (start && rdy) begin
      modelQ.push_back(data);
      sbData.push_back(data);
    end
    @(posedge clk);
    #1;
    checkOutput("tx_end", ifc.tx_end, endExp);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && (inFrame || modelQ.size() != 0); n++)
      applyStimulus(1'b0, 8'($urandom));
    repeat (3) applyStimulus(1'b0, 8'($urandom));
    checks++;
    if (inFrame || modelQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: still pending after %0d cycles", budget);
    end
  endtask

  // Line receiver: finds a start bit, samples mid-bit and scores the frame.
  initial begin : monitor
    int         s;
    logic [9:0] bits;
    bit         aborted;
    forever begin
      @(posedge clk);
      #1;
      if (reset !== 1'b0 || ifc.tx !== 1'b0) continue;
      s = edgeCnt;
      aborted = 1'b0;
      bits = '0;
      for (int i = 0; i < 10 && !aborted; i++) begin
        while (edgeCnt < s + i * D + D / 2 && !aborted) begin
          @(posedge clk);
          #1;
          if (reset !== 1'b0) aborted = 1'b1;
        end
        bits[i] = ifc.tx;
      end
      if (!aborted) begin
        checkOutput("start_bit", bits[0], 1'b0);
        checkOutput("stop_bit", bits[9], 1'b1);
        if (sbData.size() == 0 || sbStart.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame: got byte %0h with nothing expected", bits[8:1]);
        end else begin
          checkOutput("frame_byte", bits[8:1], sbData.pop_front());
          checkOutput("frame_start_edge", s, sbStart.pop_front());
        end
      end
    end
  end

  initial begin
    ifc.tx_start = 1'b0;
    ifc.tx_data  = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_tx", ifc.tx, 1'b1);
    checkOutput("reset_end", ifc.tx_end, 1'b0);
    checkOutput("reset_busy", ifc.tx_busy, 1'b0);
    checkOutput("reset_ready", ifc.tx_ready, 1'b1);
    reset = 1'b0;

    applyStimulus(1'b1, 8'hA5);
    drain(100);

    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'hFF);
    drain(200);

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h10 + i));
    drain(400);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom));
    repeat (10 * D + 4) applyStimulus(1'b1, 8'($urandom));
    drain(400);

    applyStimulus(1'b1, 8'h3C);
    repeat (17) applyStimulus(1'b0, 8'($urandom));
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_tx", ifc.tx, 1'b1);
    checkOutput("midreset_busy", ifc.tx_busy, 1'b0);
    checkOutput("midreset_ready", ifc.tx_ready, 1'b1);
    checkOutput("midreset_end", ifc.tx_end, 1'b0);
    modelQ.delete();
    sbData.delete();
    sbStart.delete();
    inFrame = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_end_hold", ifc.tx_end, 1'b0);
    checkOutput("midreset_tx_hold", ifc.tx, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 8'h3C);
    drain(200);

    repeat (400) applyStimulus($urandom_range(0, 3) == 0, 8'($urandom));
    drain(400);

    checkOutput("scoreboard_empty", sbData.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- Parameters: one per line, as name, default, meaning.
  - REQ-001 DIV_RATE, 260, clocks per UART bit period; legal range 2..65535.
  - REQ-002 FIFO_DEPTH, 4, transmit FIFO entries; power of two, at least 2.
- Ports: one per line, as name, direction, width, meaning.
  - REQ-003 clk  in  1  single clock; all logic on rising edge.
  - REQ-004 reset  in  1  asynchronous, active-high reset.
  - REQ-005 tx_start  in  1  write strobe; request to enqueue tx_data.
  - REQ-006 tx_data  in  8  byte to enqueue.
  - REQ-007 tx_ready  out  1  FIFO not full; equals (count < FIFO_DEPTH), decoded from the registered count.
  - REQ-008 tx_busy  out  1  high when state != IDLE or count != 0.
  - REQ-009 tx_end  out  1  registered one-cycle pulse per completed frame.
  - REQ-010 tx  out  1  registered UART serial output; idle/mark level is 1.

Function
- FIFO push and pop
  - REQ-011 A push SHALL occur on any edge where tx_start && tx_ready. When tx_start && !tx_ready, the byte SHALL be dropped with no other effect.
  - REQ-012 tx_ready SHALL use the pre-edge count; a pop on the same edge SHALL NOT make a push accepted while full.
  - REQ-013 Count SHALL update by +push - pop. Simultaneous push and pop SHALL leave count unchanged.
  - REQ-014 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
- Frame format
  - REQ-015 Each frame SHALL be: start bit 0, then 8 data bits LSB first, then stop bit 1. No parity.
  - REQ-016 Each bit SHALL drive tx for exactly DIV_RATE clocks, giving a frame of 10*DIV_RATE clocks.
- State machine and timing
  - REQ-017 States SHALL be IDLE, START, DATA, STOP. A down-counter div_cnt of width clog2(DIV_RATE) and a 3-bit bit_cnt SHALL track position.
  - REQ-018 IDLE with count != 0: the block SHALL pop, load the shift register, set tx <= 0, set div_cnt <= DIV_RATE-1, and go to START.
  - REQ-019 START/DATA/STOP: when div_cnt != 0, decrement it. When div_cnt == 0, advance to the next bit and reload DIV_RATE-1.
  - REQ-020 START -> DATA drives tx <= bit0. DATA shifts right each bit period. After bit_cnt 7, go to STOP with tx <= 1.
  - REQ-021 STOP with div_cnt == 0: set tx_end <= 1 for one cycle.
    - If count != 0, pop immediately and go to START with tx <= 0 (back-to-back, no idle gap).
    - Otherwise go to IDLE with tx held at 1.
  - REQ-022 Latency: tx_start accepted at edge N into an empty, idle block SHALL give tx = 0 from edge N+1, and tx_end high for the cycle after edge N+1+10*DIV_RATE.
  - REQ-023 tx_data SHALL be captured at the push edge; later changes to tx_data SHALL NOT affect queued or in-flight bytes.
  - REQ-024 tx_end SHALL be 0 in every cycle other than the REQ-021 pulse.

Reset
- REQ-025 On reset assertion, asynchronously and regardless of edges, the block SHALL set:
  - tx = 1, tx_end = 0, state = IDLE
  - count = 0, pointers = 0, div_cnt = 0, bit_cnt = 0
  - tx_busy = 0, tx_ready = 1
- REQ-026 Reset mid-frame SHALL abort the frame, discard FIFO contents, and emit no tx_end.
- REQ-027 After deassertion, the block SHALL accept a push on the first edge.

Verification (bench uses DIV_RATE = 4, FIFO_DEPTH = 4)
- REQ-028 Push 0xA5 at edge 0 -> tx from edge 1 = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks. tx_end high only for the cycle after edge 41. tx_busy falls after edge 41.
- REQ-029 Push 0x01 then 0xFF on consecutive edges -> the second start bit begins at edge 41 with no idle gap. Exactly two tx_end pulses, at edges 41 and 81.
- REQ-030 Push 0x10..0x15 on six consecutive edges -> 0x10..0x14 are transmitted in order. tx_ready is low at edge 5, so 0x15 is dropped. Five tx_end pulses.
- REQ-031 While full, tx_start is held high through the STOP->START pop edge -> that byte is not accepted. The next edge accepts it (count goes 3 -> 4).
- REQ-032 Assert reset at clock 17 of a 0x3C frame -> tx = 1 and tx_busy = 0 immediately. No tx_end. A fresh 0x3C after release transmits correctly.
- REQ-033 Change tx_data every cycle after each push; a receiver model decodes every frame and checks byte values and 10*DIV_RATE frame spacing.
